// File: rtl/unpack_n.sv
// Parallel-to-serial unpacker: one N x DW vector in, N element beats out (LSB element first).
// Latency: vector captured at edge t is presented in cycle t+1; N beats per vector, no bubble between vectors.
// Backpressure: out_ready low freezes the beat; in_ready only rises when idle or on an accepted last beat.
// Optional running sum on out_sum: define UNPACK_N_SUM_EN.
module unpack_n #(
    parameter int N  = 4,
    parameter int DW = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] inp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    output logic [DW-1:0]   out_sum
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t            state_q, state_d;
    logic [N*DW-1:0]   shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              capture;
    logic              accept;

    assign out_valid = (state_q == SEND);
    assign out_data  = shreg_q[DW-1:0];
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
    assign capture   = in_valid && in_ready;
    assign accept    = out_valid && out_ready;

    // Shift on every accepted beat so the register drains to zero once the vector is done.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (capture) begin
            state_d = SEND;
            shreg_d = inp;
            idx_d   = '0;
        end else if (accept) begin
            shreg_d = shreg_q >> DW;
            if (out_last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

`ifdef UNPACK_N_SUM_EN
    logic [DW-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (capture) begin
            acc_d = '0;
        end else if (accept) begin
            acc_d = out_last ? '0 : acc_q + out_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out_sum = out_valid ? acc_q + out_data : '0;
`else
    assign out_sum = '0;
`endif

endmodule

// File: tb/tb_unpack_n.sv
// Directed bench for unpack_n: cycle table on an N=4 instance plus hand sequences for reset and N=1.
module tb_unpack_n;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [N*DW-1:0] inp;
    logic            out_valid, out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_idx;
    logic            out_last;
    logic [DW-1:0]   out_sum;

    logic            in_valid1, in_ready1;
    logic [DW-1:0]   inp1;
    logic            out_valid1, out_ready1;
    logic [DW-1:0]   out_data1;
    logic [0:0]      out_idx1;
    logic            out_last1;
    logic [DW-1:0]   out_sum1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    unpack_n #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_sum(out_sum)
    );

    unpack_n #(.N(1), .DW(DW)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .inp(inp1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .out_idx(out_idx1), .out_last(out_last1), .out_sum(out_sum1)
    );

    typedef struct {
        logic            rst;
        logic            iv;
        logic [N*DW-1:0] inp;
        logic            ordy;
        logic            e_ir;
        logic            e_ov;
        logic [DW-1:0]   e_data;
        logic [1:0]      e_idx;
        logic            e_last;
        logic [DW-1:0]   e_sum;
    } vec_t;

    vec_t vecs[$];

    // Running sum only exists when the feature is built; otherwise the port is tied low.
    function automatic logic [DW-1:0] es(input logic [DW-1:0] s);
`ifdef UNPACK_N_SUM_EN
        return s;
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic ordy,
                       input logic ir, input logic ov, input logic [7:0] dat,
                       input logic [1:0] idx, input logic last, input logic [7:0] sum);
        vec_t v;
        v.rst = r; v.iv = iv; v.inp = d; v.ordy = ordy;
        v.e_ir = ir; v.e_ov = ov; v.e_data = dat; v.e_idx = idx; v.e_last = last; v.e_sum = sum;
        vecs.push_back(v);
    endtask

    localparam logic [31:0] A = 32'h0403_0201;
    localparam logic [31:0] B = 32'h0807_0605;
    localparam logic [31:0] C = 32'h0D0C_0B0A;
    localparam logic [31:0] F = 32'hFFFF_FFFF;

    initial begin
        // single vector
        add(0,1,A,1, 1,0,8'h00,0,0,8'h00);
        add(0,0,0,1, 0,1,8'h01,0,0,8'h01);
        add(0,0,0,1, 0,1,8'h02,1,0,8'h03);
        add(0,0,0,1, 0,1,8'h03,2,0,8'h06);
        add(0,0,0,1, 1,1,8'h04,3,1,8'h0A);
        add(0,0,0,1, 1,0,8'h00,0,0,8'h00);
        // backpressure at idx 1, with a competing vector offered while busy
        add(0,1,A,1, 1,0,8'h00,0,0,8'h00);
        add(0,0,0,1, 0,1,8'h01,0,0,8'h01);
        add(0,1,32'hDEADBEEF,0, 0,1,8'h02,1,0,8'h03);
        add(0,1,32'hDEADBEEF,0, 0,1,8'h02,1,0,8'h03);
        add(0,1,32'hDEADBEEF,0, 0,1,8'h02,1,0,8'h03);
        add(0,0,0,1, 0,1,8'h02,1,0,8'h03);
        add(0,0,0,1, 0,1,8'h03,2,0,8'h06);
        add(0,0,0,1, 1,1,8'h04,3,1,8'h0A);
        add(0,0,0,1, 1,0,8'h00,0,0,8'h00);
        // back-to-back
        add(0,1,A,1, 1,0,8'h00,0,0,8'h00);
        add(0,1,B,1, 0,1,8'h01,0,0,8'h01);
        add(0,1,B,1, 0,1,8'h02,1,0,8'h03);
        add(0,1,B,1, 0,1,8'h03,2,0,8'h06);
        add(0,1,B,1, 1,1,8'h04,3,1,8'h0A);
        add(0,0,0,1, 0,1,8'h05,0,0,8'h05);
        add(0,0,0,1, 0,1,8'h06,1,0,8'h0B);
        add(0,0,0,1, 0,1,8'h07,2,0,8'h12);
        add(0,0,0,1, 1,1,8'h08,3,1,8'h1A);
        add(0,0,0,1, 1,0,8'h00,0,0,8'h00);
        // wrap-around sum
        add(0,1,F,1, 1,0,8'h00,0,0,8'h00);
        add(0,0,0,1, 0,1,8'hFF,0,0,8'hFF);
        add(0,0,0,1, 0,1,8'hFF,1,0,8'hFE);
        add(0,0,0,1, 0,1,8'hFF,2,0,8'hFD);
        add(0,0,0,1, 1,1,8'hFF,3,1,8'hFC);
        add(0,0,0,1, 1,0,8'h00,0,0,8'h00);
        // reset mid-vector at idx 2, then a fresh vector
        add(0,1,A,1, 1,0,8'h00,0,0,8'h00);
        add(0,0,0,1, 0,1,8'h01,0,0,8'h01);
        add(0,0,0,1, 0,1,8'h02,1,0,8'h03);
        add(1,0,0,1, 0,1,8'h03,2,0,8'h06);
        add(0,1,C,1, 1,0,8'h00,0,0,8'h00);
        add(0,0,0,1, 0,1,8'h0A,0,0,8'h0A);
        add(0,0,0,1, 0,1,8'h0B,1,0,8'h15);
        add(0,0,0,1, 0,1,8'h0C,2,0,8'h21);
        add(0,0,0,1, 1,1,8'h0D,3,1,8'h2E);
        add(0,0,0,1, 1,0,8'h00,0,0,8'h00);

        // reset held two cycles with in_valid high
        rst = 1'b1; in_valid = 1'b1; inp = A; out_ready = 1'b1;
        in_valid1 = 1'b1; inp1 = 8'h77; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
        #1;
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data",  32'(out_data),  32'd0);
        chk("rst out_idx",   32'(out_idx),   32'd0);
        chk("rst out_last",  32'(out_last),  32'd0);
        chk("rst out_sum",   32'(out_sum),   32'd0);
        chk("rst n1 out_valid", 32'(out_valid1), 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; in_valid = vecs[i].iv; inp = vecs[i].inp; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].e_data));
            chk($sformatf("v%0d out_idx", i),   32'(out_idx),   32'(vecs[i].e_idx));
            chk($sformatf("v%0d out_last", i),  32'(out_last),  32'(vecs[i].e_last));
            chk($sformatf("v%0d out_sum", i),   32'(out_sum),   32'(es(vecs[i].e_sum)));
        end

        // N=1: every beat is last, back-to-back single-beat vectors
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        in_valid1 = 1'b1; inp1 = 8'h5A; out_ready1 = 1'b1;
        #1;
        chk("n1 idle in_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        inp1 = 8'h3C;
        #1;
        chk("n1 b0 out_valid", 32'(out_valid1), 32'd1);
        chk("n1 b0 out_data",  32'(out_data1),  32'h5A);
        chk("n1 b0 out_idx",   32'(out_idx1),   32'd0);
        chk("n1 b0 out_last",  32'(out_last1),  32'd1);
        chk("n1 b0 in_ready",  32'(in_ready1),  32'd1);
        chk("n1 b0 out_sum",   32'(out_sum1),   32'(es(8'h5A)));
        @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        chk("n1 b1 out_data",  32'(out_data1),  32'h3C);
        chk("n1 b1 out_last",  32'(out_last1),  32'd1);
        @(negedge clk);
        #1;
        chk("n1 end out_valid", 32'(out_valid1), 32'd0);
        chk("n1 end out_last",  32'(out_last1),  32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
